// File: rtl/object_plotter.sv
// Rasterises one paddle or ball rectangle per accepted controller command,
// emitting one registered pixel per clock toward the VGA adapter write port.
module object_plotter #(
  parameter int unsigned PADDLE_W      = 4,
  parameter int unsigned PADDLE_H      = 10,
  parameter int unsigned BALL_SIZE     = 4,
  parameter int unsigned L_PADDLE_X    = 8,
  parameter int unsigned R_PADDLE_X    = 148,
  parameter logic [2:0]  PADDLE_COLOUR = 3'b111,
  parameter logic [2:0]  BALL_COLOUR   = 3'b010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] draw_state,
  input  logic [6:0] l_paddle_y,
  input  logic [6:0] r_paddle_y,
  input  logic [7:0] ball_x,
  input  logic [6:0] ball_y,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StPlot, StDone} state_e;

  state_e     state_q, state_d;
  logic [1:0] last_cmd_q, last_cmd_d;
  logic [7:0] base_x_q, base_x_d;
  logic [6:0] base_y_q, base_y_d;
  logic [3:0] w_q, w_d, h_q, h_d;
  logic [3:0] dx_q, dx_d, dy_q, dy_d;
  logic [2:0] col_q, col_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d, busy_q, busy_d, done_q, done_d;

  logic       accept, row_end, last_px;
  logic [8:0] x_sum, y_sum;

  assign accept  = (state_q == StIdle) && (draw_state != 2'b00) && (draw_state != last_cmd_q);
  assign row_end = (dx_q == w_q - 4'd1);
  assign last_px = row_end && (dy_q == h_q - 4'd1);
  assign x_sum   = 9'(base_x_q) + 9'(dx_q);
  assign y_sum   = 9'(base_y_q) + 9'(dy_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      last_cmd_q <= 2'b00;
      base_x_q   <= '0;
      base_y_q   <= '0;
      w_q        <= '0;
      h_q        <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      col_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
      plot_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_cmd_q <= last_cmd_d;
      base_x_q   <= base_x_d;
      base_y_q   <= base_y_d;
      w_q        <= w_d;
      h_q        <= h_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      col_q      <= col_d;
      x_q        <= x_d;
      y_q        <= y_d;
      colour_q   <= colour_d;
      plot_q     <= plot_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StPlot;
      StPlot:  if (last_px) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    last_cmd_d = last_cmd_q;
    base_x_d   = base_x_q;
    base_y_d   = base_y_q;
    w_d        = w_q;
    h_d        = h_q;
    col_d      = col_q;
    dx_d       = dx_q;
    dy_d       = dy_q;

    if (state_q == StIdle) begin
      if (draw_state == 2'b00) begin
        last_cmd_d = 2'b00;
      end else if (accept) begin
        last_cmd_d = draw_state;
        dx_d       = '0;
        dy_d       = '0;
        unique case (draw_state)
          2'b01: begin
            base_x_d = 8'(L_PADDLE_X);
            base_y_d = l_paddle_y;
            w_d      = 4'(PADDLE_W);
            h_d      = 4'(PADDLE_H);
            col_d    = PADDLE_COLOUR;
          end
          2'b11: begin
            base_x_d = 8'(R_PADDLE_X);
            base_y_d = r_paddle_y;
            w_d      = 4'(PADDLE_W);
            h_d      = 4'(PADDLE_H);
            col_d    = PADDLE_COLOUR;
          end
          default: begin
            base_x_d = ball_x;
            base_y_d = ball_y;
            w_d      = 4'(BALL_SIZE);
            h_d      = 4'(BALL_SIZE);
            col_d    = BALL_COLOUR;
          end
        endcase
      end
    end else if (state_q == StPlot) begin
      if (row_end) begin
        dx_d = '0;
        dy_d = dy_q + 4'd1;
      end else begin
        dx_d = dx_q + 4'd1;
      end
    end
  end

  // Pixel outputs lag the dx/dy walk by one register stage; clipped pixels still use a cycle.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    colour_d = 3'b000;
    plot_d   = 1'b0;
    busy_d   = (state_q != StIdle);
    done_d   = (state_q == StDone);
    if (state_q == StPlot) begin
      x_d      = x_sum[7:0];
      y_d      = y_sum[6:0];
      colour_d = col_q;
      plot_d   = (x_sum <= 9'd159) && (y_sum <= 9'd119);
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
